perf_event_collector: RTL

//  Consumer end of the core's performance-event path. Each source raises a one-cycle

---
 rtl/perf_event_collector.sv | 127 ++++++++++++
 1 files changed

// File: rtl/perf_event_collector.sv
// Per-event saturating performance counters with a snapshot-and-drain stream.
// Counting never pauses; a dump freezes a copy of every counter and sends the copy out one index per beat.
module perf_event_collector #(
  parameter int  EVENT_NUM = 16,
  parameter int  CNT_WIDTH = 32,
  localparam int IDX_WIDTH = $clog2(EVENT_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EVENT_NUM-1:0] event_i,
  input  logic                 clear_req,
  input  logic                 dump_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic [CNT_WIDTH-1:0] out_cnt,
  output logic [63:0]          out_cycle,
  output logic                 out_last,
  output logic                 busy,
  output logic [63:0]          cycle_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(EVENT_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic                 snap_load;
  logic [CNT_WIDTH-1:0] cnt_q  [EVENT_NUM];
  logic [CNT_WIDTH-1:0] cnt_d  [EVENT_NUM];
  logic [CNT_WIDTH-1:0] snap_q [EVENT_NUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
    end
  end

  // A clear wins over a same-cycle event; a full counter holds instead of wrapping.
  always_comb begin
    for (int i = 0; i < EVENT_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_req) begin
        cnt_d[i] = '0;
      end else if (event_i[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < EVENT_NUM; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      out_cycle <= '0;
    end else begin
      for (int i = 0; i < EVENT_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (snap_load) begin
          snap_q[i] <= cnt_q[i];
        end
      end
      if (snap_load) begin
        out_cycle <= cycle_cnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Stream: a beat transfers on a cycle where out_valid && out_ready; once
  // out_valid rises it stays high with idx/cnt/last/cycle frozen until that
  // transfer happens, and the source never withdraws a beat.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    snap_load = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_idx   = '0;
    out_cnt   = '0;
    out_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          snap_load = 1'b1;
          ptr_d     = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_idx   = ptr_q;
        out_cnt   = snap_q[ptr_q];
        out_last  = (ptr_q == LAST_IDX);
        if (out_ready) begin
          if (ptr_q == LAST_IDX) begin
            ptr_d   = '0;
            state_d = ST_IDLE;
          end else begin
            ptr_d = ptr_q + IDX_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
